// File: rtl/usb_tx_pkg.sv
// Shared types, constants and small decode helpers for the USB low-level transmitter.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_STUFF   = 3'd3,
        S_ABORT   = 3'd4,
        S_EOP_SE0 = 3'd5,
        S_EOP_J   = 3'd6
    } usb_tx_state_t;

    // SYNC is shifted out LSB first: seven 0s (KJKJKJK) then a 1 (K held).
    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LIMIT  = 6;
    localparam int         EOP_SE0_BITS = 2;
    localparam int         ABORT_BITS   = 7;

    // True in the states that shift real bits (SYNC or a data byte).
    function automatic logic is_shift_state(input usb_tx_state_t st);
        return (st == S_SYNC) || (st == S_DATA);
    endfunction

    // Raw (pre-NRZI) bit sent in a state: shift-register LSB while shifting,
    // a forced 0 for a stuff bit, and 1 (line held) everywhere else.
    function automatic logic raw_bit_of(input usb_tx_state_t st, input logic lsb);
        if (is_shift_state(st)) return lsb;
        if (st == S_STUFF)      return 1'b0;
        return 1'b1;
    endfunction

    // Byte boundary: bit 7 of SYNC/byte with no stuff bit pending, or the
    // stuff bit that follows bit 7. This is exactly the TXReady cycle.
    function automatic logic boundary_of(input usb_tx_state_t st,
                                         input logic [2:0]    bit_idx,
                                         input logic [2:0]    ones,
                                         input logic          lsb);
        logic stuff_pending;
        stuff_pending = lsb && (ones == 3'(STUFF_LIMIT - 1));
        return (is_shift_state(st) && (bit_idx == 3'd7) && !stuff_pending) ||
               ((st == S_STUFF) && (bit_idx == 3'd7));
    endfunction

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI level tracking and J/K/SE0 line encoding for the USB transmitter.
module usb_nrzi_enc (
    input  logic clk,
    input  logic RST,
    input  logic raw_bit,
    input  logic se0,
    input  logic hold,
    output logic tx_dp,
    output logic tx_dm
);

    // Level of the previous bit time; 1 means J.
    logic level_q;
    logic line_lvl;

    // Current bit's level: raw 0 toggles, raw 1 (or hold) keeps the previous level.
    always_comb begin
        line_lvl = (hold || raw_bit) ? level_q : ~level_q;
    end

    assign tx_dp = !se0 && line_lvl;
    assign tx_dm = !se0 && !line_lvl;

    // Remember the level just driven; SE0 re-arms the line to J for the next packet.
    always_ff @(posedge clk or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RST)      level_q <= 1'b1;
        else if (se0) level_q <= 1'b1;
        else          level_q <= line_lvl;
    end

endmodule

// File: rtl/usb_tx_fsm.sv
// USB transmit state machine: SYNC, bit-stuffed data bytes, abort, EOP.
module usb_tx_fsm (
    input  logic       clk,
    input  logic       RST,
    input  logic       TXValid,
    input  logic [7:0] TXData,
    input  logic       TXAbort,
    output logic       TXReady,
    output logic       tx_dp,
    output logic       tx_dm,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       frame_done
);

    import usb_tx_pkg::*;

    usb_tx_state_t state_q, state_n;
    logic [2:0]    bit_q, bit_n;
    logic [2:0]    ones_q, ones_n;
    logic [7:0]    shreg_q, shreg_n;
    logic [1:0]    eop_q, eop_n;
    logic [2:0]    abort_q, abort_n;

    logic raw_cur;
    logic stuff_cur;
    logic at_boundary;
    logic ready_n;
    logic line_se0;
    logic line_hold;

    // Next-state and datapath decode from the current registers and inputs.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case leaves a value unassigned and infers a latch.
        state_n = state_q;
        bit_n   = bit_q;
        ones_n  = ones_q;
        shreg_n = shreg_q;
        eop_n   = eop_q;
        abort_n = abort_q;

        raw_cur     = raw_bit_of(state_q, shreg_q[0]);
        stuff_cur   = is_shift_state(state_q) && raw_cur && (ones_q == 3'(STUFF_LIMIT - 1));
        at_boundary = boundary_of(state_q, bit_q, ones_q, shreg_q[0]);

        case (state_q)
            S_IDLE: begin
                if (TXValid) begin
                    state_n = S_SYNC;
                    shreg_n = SYNC_PATTERN;
                    bit_n   = 3'd0;
                    ones_n  = 3'd0;
                end
            end
            S_SYNC, S_DATA: begin
                if (TXAbort) begin
                    state_n = S_ABORT;
                    abort_n = 3'd0;
                end else begin
                    ones_n  = raw_cur ? (ones_q + 3'd1) : 3'd0;
                    shreg_n = shreg_q >> 1;
                    if (stuff_cur)         state_n = S_STUFF;
                    else if (!at_boundary) bit_n   = bit_q + 3'd1;
                end
            end
            S_STUFF: begin
                if (TXAbort) begin
                    state_n = S_ABORT;
                    abort_n = 3'd0;
                end else begin
                    ones_n = 3'd0;
                    if (!at_boundary) begin
                        bit_n   = bit_q + 3'd1;
                        state_n = S_DATA;
                    end
                end
            end
            S_ABORT: begin
                if (abort_q == 3'(ABORT_BITS - 1)) begin
                    state_n = S_EOP_SE0;
                    eop_n   = 2'd0;
                end else begin
                    abort_n = abort_q + 3'd1;
                end
            end
            S_EOP_SE0: begin
                if (eop_q == 2'(EOP_SE0_BITS - 1)) state_n = S_EOP_J;
                else                               eop_n   = eop_q + 2'd1;
            end
            S_EOP_J: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Byte boundary: take the next byte or close the packet; abort wins.
        if (at_boundary && !TXAbort) begin
            bit_n = 3'd0;
            if (TXValid) begin
                state_n = S_DATA;
                shreg_n = TXData;
            end else begin
                state_n = S_EOP_SE0;
                eop_n   = 2'd0;
            end
        end

        // TXReady is registered, so predict next cycle's boundary from next-state values.
        ready_n = boundary_of(state_n, bit_n, ones_n, shreg_n[0]);
    end

    // State, counters, shift register and registered status outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            bit_q      <= 3'd0;
            ones_q     <= 3'd0;
            shreg_q    <= 8'd0;
            eop_q      <= 2'd0;
            abort_q    <= 3'd0;
            TXReady    <= 1'b0;
            tx_oe      <= 1'b0;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            bit_q      <= bit_n;
            ones_q     <= ones_n;
            shreg_q    <= shreg_n;
            eop_q      <= eop_n;
            abort_q    <= abort_n;
            TXReady    <= ready_n;
            tx_oe      <= (state_n != S_IDLE);
            tx_busy    <= (state_n != S_IDLE);
            frame_done <= (state_n == S_EOP_J);
        end
    end

    // Line control: SE0 during EOP, level frozen wherever no bit is being coded.
    always_comb begin
        line_se0  = (state_q == S_EOP_SE0);
        line_hold = !(is_shift_state(state_q) || (state_q == S_STUFF)) && !line_se0;
    end

    usb_nrzi_enc u_nrzi (
        .clk     (clk),
        .RST     (RST),
        .raw_bit (raw_cur),
        .se0     (line_se0),
        .hold    (line_hold),
        .tx_dp   (tx_dp),
        .tx_dm   (tx_dm)
    );

endmodule

// File: tb/tb_usb_tx_fsm.sv
// Self-checking bench for usb_tx_fsm against a bit-stream reference model.
module tb_usb_tx_fsm;

    logic       clk = 1'b0;
    logic       RST;
    logic       TXValid;
    logic [7:0] TXData;
    logic       TXAbort;
    logic       TXReady;
    logic       tx_dp, tx_dm, tx_oe, tx_busy, frame_done;

    typedef logic [7:0] bq_t[$];

    // Observed/expected vector: frame_done, TXReady, tx_busy, tx_oe, tx_dm, tx_dp.
    typedef struct packed {
        logic fd;
        logic rdy;
        logic busy;
        logic oe;
        logic dm;
        logic dp;
    } obs_t;

    localparam obs_t IDLE_OBS = 6'b000001;

    int   errors   = 0;
    int   checks   = 0;
    int   frame_no = 0;
    int   bit_len  = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    usb_tx_fsm dut (
        .clk        (clk),
        .RST        (RST),
        .TXValid    (TXValid),
        .TXData     (TXData),
        .TXAbort    (TXAbort),
        .TXReady    (TXReady),
        .tx_dp      (tx_dp),
        .tx_dm      (tx_dm),
        .tx_oe      (tx_oe),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    function automatic obs_t observed();
        return {frame_done, TXReady, tx_busy, tx_oe, tx_dm, tx_dp};
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed fd/rdy/busy/oe/dm/dp=%b required=%b", tag, obs, exp);
        end
    endtask

    // Reference model: raw stream with stuffing, NRZI levels, then abort/EOP tail.
    task automatic build(input bq_t bytes, input int abort_at);
        logic       raw_s[$];
        logic       rdy_s[$];
        logic [7:0] grp;
        logic       lvl;
        int         ones;
        ones = 0;
        exp_q.delete();
        for (int g = 0; g <= bytes.size(); g++) begin
            grp = (g == 0) ? 8'h80 : bytes[g-1];
            for (int b = 0; b < 8; b++) begin
                raw_s.push_back(grp[b]);
                rdy_s.push_back(1'b0);
                ones = grp[b] ? ones + 1 : 0;
                if (ones == 6) begin
                    raw_s.push_back(1'b0);
                    rdy_s.push_back(1'b0);
                    ones = 0;
                end
            end
            rdy_s[rdy_s.size()-1] = 1'b1;
        end
        if (abort_at > 0) begin
            while (raw_s.size() > abort_at) begin
                void'(raw_s.pop_back());
                void'(rdy_s.pop_back());
            end
        end
        bit_len = raw_s.size();
        lvl = 1'b1;
        for (int i = 0; i < raw_s.size(); i++) begin
            if (!raw_s[i]) lvl = !lvl;
            exp_q.push_back({1'b0, rdy_s[i], 1'b1, 1'b1, !lvl, lvl});
        end
        if (abort_at > 0)
            for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, !lvl, lvl});
        exp_q.push_back(6'b001100);
        exp_q.push_back(6'b001100);
        exp_q.push_back(6'b101101);
    endtask

    // One idle launch cycle, then the modelled frame; inputs follow the model's ready cycles.
    task automatic run_frame(input bq_t bytes, input int abort_at,
                             input logic hold_valid, input int stop_after);
        int taken;
        taken = 0;
        frame_no++;
        build(bytes, abort_at);
        @(negedge clk);
        check($sformatf("f%0d_idle", frame_no), observed(), IDLE_OBS);
        TXValid = 1'b1;
        TXData  = 8'($urandom);
        TXAbort = 1'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (stop_after > 0 && i == stop_after) return;
            @(negedge clk);
            check($sformatf("f%0d_c%0d", frame_no, i + 1), observed(), exp_q[i]);
            if (i < bit_len) TXAbort = (i + 1 == abort_at);
            else             TXAbort = 1'($urandom);
            if (taken < bytes.size()) begin
                TXValid = 1'b1;
                TXData  = bytes[taken];
            end else begin
                TXValid = (i >= bit_len) ? hold_valid : 1'b0;
                TXData  = 8'($urandom);
            end
            if (exp_q[i].rdy) taken++;
        end
    endtask

    initial begin
        bq_t b;
        int  a;
        RST     = 1'b0;
        TXValid = 1'b0;
        TXAbort = 1'b0;
        TXData  = 8'd0;
        #3 RST = 1'b1;
        #1 check("reset_state", observed(), IDLE_OBS);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;

        // Single zero byte: KJKJKJKK JKJKJKJK SE0 SE0 J, 19 enabled cycles.
        b = {8'h00};
        run_frame(b, 0, 1'b0, 0);
        // Two 0xFF bytes: stuff after byte 0 bit 4 and after byte 1 bit 2.
        b = {8'hFF, 8'hFF};
        run_frame(b, 0, 1'b0, 0);
        // 0x3F: SYNC's trailing 1 makes the run six long at bit 4.
        b = {8'h3F};
        run_frame(b, 0, 1'b0, 0);
        // 0xFC: run of six ends on bit 7, so TXReady moves into the stuff cycle before EOP.
        b = {8'hFC};
        run_frame(b, 0, 1'b0, 0);
        // Stuff at a boundary with a following byte.
        b = {8'hFC, 8'h81};
        run_frame(b, 0, 1'b0, 0);
        // Abort on data bit 3 of the first byte (cycle 12).
        b = {8'hA5, 8'h77};
        run_frame(b, 12, 1'b0, 0);
        // Back-to-back: TXValid held through EOP J, exactly one idle cycle between.
        b = {8'h5A};
        run_frame(b, 0, 1'b1, 0);
        b = {8'hC3};
        run_frame(b, 0, 1'b0, 0);

        // Reset in the middle of SYNC/data.
        b = {8'hFF, 8'h12};
        run_frame(b, 0, 1'b0, 10);
        #2 RST = 1'b1;
        #1 check("reset_midframe", observed(), IDLE_OBS);
        TXValid = 1'b0;
        TXAbort = 1'b0;
        @(negedge clk);
        check("reset_held", observed(), IDLE_OBS);
        RST = 1'b0;
        @(negedge clk);
        check("reset_release_idle", observed(), IDLE_OBS);

        // Randomized frames, biased toward long runs of 1s, some aborted.
        for (int f = 0; f < 24; f++) begin
            b.delete();
            for (int k = 0; k < 1 + int'($urandom % 3); k++) begin
                case ($urandom % 4)
                    0:       b.push_back(8'hFF);
                    1:       b.push_back(8'($urandom));
                    default: b.push_back(8'($urandom) | 8'($urandom));
                endcase
            end
            a = 0;
            if ($urandom % 4 == 0) begin
                build(b, 0);
                a = 1 + int'($urandom % bit_len);
                if (exp_q[a-1].rdy) a = a - 1;
            end
            run_frame(b, a, 1'($urandom), 0);
        end

        @(negedge clk);
        TXValid = 1'b0;
        TXAbort = 1'b0;
        check("final_idle0", observed(), IDLE_OBS);
        @(negedge clk);
        check("final_idle1", observed(), IDLE_OBS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
